// File: rtl/signed_divider32_if.sv
// ---------------------------------------------------------------------------
// signed_divider32_if
//
// Purpose : Issue/result bundle between the pipeline and the multi-cycle
//           signed divider (DIV execution unit).
// Signals :
//   ctrl_DIV        start pulse; operands are sampled on the same edge
//   data_operandA   dividend, two's complement
//   data_operandB   divisor, two's complement
//   data_result     registered quotient, truncated toward zero
//   data_exception  divide-by-zero flag, valid while data_resultRDY is high
//   data_resultRDY  one-cycle result-valid pulse
// Modports: master = pipeline side (issues), slave = divider side.
// ---------------------------------------------------------------------------
interface signed_divider32_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/signed_divider32.sv
// ---------------------------------------------------------------------------
// signed_divider32
//
// Purpose : Multi-cycle signed 32-bit integer divider. Computes A / B,
//           truncated toward zero, by restoring shift-subtract over 32
//           iterations on the operand magnitudes, then restores the sign.
// Ports   :
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    signed_divider32_if.slave (ctrl_DIV, operands, result,
//          exception, resultRDY)
// Timing  : a normal divide accepted on edge E0 presents its result after
//           E32 (RDY high for one cycle); divide-by-zero answers after E0.
//           Starts are accepted in IDLE or DONE only and ignored in RUN.
// ---------------------------------------------------------------------------
module signed_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    signed_divider32_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Control registers (reset)
    logic [4:0]       cnt_q;
    logic             rdy_q;
    logic             exc_q;
    logic [WIDTH-1:0] result_q;

    // Datapath registers (no reset needed; only meaningful in RUN)
    logic [WIDTH-1:0] rem_q;    // partial remainder, always < divisor
    logic [WIDTH-1:0] quo_q;    // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q;    // divisor magnitude
    logic             sign_q;   // quotient sign

    // FSM decode strobes
    logic start_ok;
    logic step;
    logic finish;
    logic b_zero;

    // Iteration datapath
    logic [WIDTH:0]          rem_shift;
    logic signed [WIDTH:0]   trial;
    logic                    trial_ok;
    logic [WIDTH-1:0]        quo_next;

    // Two's complement negation through the bitwise-invert datapath.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Magnitude. The most negative value maps to itself, which reads as the
    // correct unsigned magnitude 2^(WIDTH-1) in the unsigned datapath.
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction

    assign b_zero = (bus.data_operandB == '0);

    // One restoring step: shift {remainder, dividend} left by one and try
    // subtracting the divisor at WIDTH+1 bits. The shifted remainder fits in
    // WIDTH+1 bits because the stored remainder is always below the divisor.
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial     = $signed(rem_shift) - $signed({1'b0, dvs_q});
    assign trial_ok  = ~trial[WIDTH];
    assign quo_next  = {quo_q[WIDTH-2:0], trial_ok};

    // ---- FSM: next state and strobes ----
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.ctrl_DIV) begin
                    start_ok = 1'b1;
                    state_d  = b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == 5'd31) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- FSM: state register ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- Control and result registers ----
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= 5'd0;
            rdy_q    <= 1'b0;
            exc_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (start_ok) begin
                cnt_q <= 5'd0;
            end else if (step) begin
                cnt_q <= cnt_q + 5'd1;
            end

            // RDY/exception are high only for the cycle spent in DONE.
            rdy_q <= (start_ok && b_zero) || finish;
            exc_q <= start_ok && b_zero;

            if (start_ok && b_zero) begin
                result_q <= '0;
            end else if (finish) begin
                result_q <= sign_q ? negate(quo_next) : quo_next;
            end
        end
    end

    // ---- Iteration datapath ----
    always_ff @(posedge clock) begin
        if (start_ok && !b_zero) begin
            rem_q  <= '0;
            quo_q  <= abs_val(bus.data_operandA);
            dvs_q  <= abs_val(bus.data_operandB);
            sign_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        end else if (step) begin
            rem_q <= trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quo_q <= quo_next;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_signed_divider32.sv
// ---------------------------------------------------------------------------
// tb_signed_divider32
//
// Purpose : Directed, table-driven bench for signed_divider32, with
//           hand-written sequences for busy-ignore, back-to-back issue in
//           the DONE cycle and mid-run reset.
// ---------------------------------------------------------------------------
module tb_signed_divider32;

    logic clock;
    logic reset;

    signed_divider32_if #(.WIDTH(32)) bus ();

    signed_divider32 #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive a start pulse at the next edge (E0); returns at the negedge after E0.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;
        bus.data_operandB = 32'h0000_0000;
    endtask

    // Count edges until RDY is seen at a negedge, bounded by max_cycles.
    task automatic wait_rdy(input int max_cycles, output int n);
        n = 0;
        while (!bus.data_resultRDY && n < max_cycles) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        int lat;
        int extra;
        int rdy_seen;

        tests_run    = 0;
        tests_failed = 0;

        //            a              b              q              exc   lat
        vecs[0]  = '{32'd100,       32'd7,         32'h0000000E,  1'b0, 32};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  1'b0, 32};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  1'b0, 32};
        vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'h0000000E,  1'b0, 32};
        vecs[4]  = '{32'd5,         32'd9,         32'h00000000,  1'b0, 32};
        vecs[5]  = '{32'hFFFFFFFF,  32'd2,         32'h00000000,  1'b0, 32};
        vecs[6]  = '{32'd7,         32'd0,         32'h00000000,  1'b1, 0};
        vecs[7]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 32};
        vecs[8]  = '{32'h80000000,  32'd1,         32'h80000000,  1'b0, 32};
        vecs[9]  = '{32'h7FFFFFFF,  32'h7FFFFFFF,  32'h00000001,  1'b0, 32};
        vecs[10] = '{32'd1000000,   32'hFFFFFFFD,  32'hFFFAE9EB,  1'b0, 32};
        vecs[11] = '{32'hFFFFFFFE,  32'd0,         32'h00000000,  1'b1, 0};

        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        reset             = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_result", bus.data_result, 32'h0);
        check("reset_exc",    {31'b0, bus.data_exception}, 32'h0);
        check("reset_rdy",    {31'b0, bus.data_resultRDY}, 32'h0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            start_div(vecs[i].a, vecs[i].b);
            wait_rdy(40, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_result", i), bus.data_result, vecs[i].q);
            check($sformatf("v%0d_exc", i), {31'b0, bus.data_exception}, {31'b0, vecs[i].exc});
            @(posedge clock);
            @(negedge clock);
            check($sformatf("v%0d_rdy_drop", i), {31'b0, bus.data_resultRDY}, 32'h0);
            check($sformatf("v%0d_exc_drop", i), {31'b0, bus.data_exception}, 32'h0);
            check($sformatf("v%0d_hold", i), bus.data_result, vecs[i].q);
        end

        // Busy: a start at E10 of a 100/7 run is ignored
        start_div(32'd100, 32'd7);
        for (int i = 1; i < 10; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        start_div(32'd9, 32'd3);
        wait_rdy(40, extra);
        check("busy_latency", 10 + extra, 32);
        check("busy_result", bus.data_result, 32'h0000000E);
        check("busy_exc", {31'b0, bus.data_exception}, 32'h0);

        // Back-to-back: issue 9/3 in the DONE cycle
        start_div(32'd9, 32'd3);
        check("b2b_rdy_drop", {31'b0, bus.data_resultRDY}, 32'h0);
        wait_rdy(40, lat);
        check("b2b_latency", lat, 32);
        check("b2b_result", bus.data_result, 32'h00000003);
        @(posedge clock);
        @(negedge clock);

        // Reset at E15 of a run, with a start presented on the reset edge
        start_div(32'd100, 32'd7);
        for (int i = 1; i < 15; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd20;
        bus.data_operandB = 32'd4;
        @(posedge clock);
        @(negedge clock);
        reset        = 1'b0;
        bus.ctrl_DIV = 1'b0;
        check("rst_mid_result", bus.data_result, 32'h0);
        check("rst_mid_exc", {31'b0, bus.data_exception}, 32'h0);
        check("rst_mid_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.data_resultRDY) rdy_seen++;
        end
        check("rst_no_rdy", rdy_seen, 0);
        start_div(32'd20, 32'd4);
        wait_rdy(40, lat);
        check("post_rst_latency", lat, 32);
        check("post_rst_result", bus.data_result, 32'h00000005);
        check("post_rst_exc", {31'b0, bus.data_exception}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
